// File: rtl/clock_cross_event_merge.sv
// Receive side of a multi-channel toggle-handshake crossing. Each channel has its toggle
// synchronised, its events counted, and is served on one round-robin valid/ready stream.
module clock_cross_event_merge #(
  parameter int CHANNELS    = 4,
  parameter int META_STAGES = 2,
  parameter int COUNT_WIDTH = 4,
  localparam int CH_WIDTH   = (CHANNELS <= 2) ? 1 : $clog2(CHANNELS)
) (
  input  logic                            clock,
  input  logic                            areset_n,
  input  logic [CHANNELS-1:0]             toggle_in,
  output logic [CHANNELS-1:0]             ack_toggle_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CH_WIDTH-1:0]             out_channel,
  output logic [CHANNELS*COUNT_WIDTH-1:0] pending,
  output logic [CHANNELS-1:0]             overflow,
  input  logic [CHANNELS-1:0]             overflow_clear
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic [CHANNELS-1:0] w_event;
  logic [CHANNELS-1:0] w_cons;
  logic [CHANNELS-1:0] w_nonzero;
  logic                w_accept;
  logic                w_rr_found;
  logic [CH_WIDTH-1:0] w_rr_ch;
  int                  w_idx;

  logic                r_hold_valid;
  logic [CH_WIDTH-1:0] r_hold_ch;
  logic [CH_WIDTH-1:0] r_rr_ptr;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_channel
      logic [META_STAGES-1:0] r_sync;
      logic                   r_edge;
      logic [COUNT_WIDTH-1:0] r_count;
      logic                   r_overflow;
      logic                   r_ack;

      // r_sync[0] is the only flop that may go metastable; r_edge marks the last value seen.
      always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
          r_sync <= '0;
          r_edge <= 1'b0;
        end else begin
          r_sync <= {r_sync[META_STAGES-2:0], toggle_in[gi]};
          r_edge <= r_sync[META_STAGES-1];
        end
      end

      assign w_event[gi]   = r_sync[META_STAGES-1] ^ r_edge;
      assign w_cons[gi]    = w_accept && (out_channel == CH_WIDTH'(gi));
      assign w_nonzero[gi] = (r_count != '0);

      // A simultaneous arrival and consumption cancel, even when the counter is full.
      always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
          r_count    <= '0;
          r_overflow <= 1'b0;
          r_ack      <= 1'b0;
        end else begin
          case ({w_event[gi], w_cons[gi]})
            2'b10: begin
              if (r_count != COUNT_MAX) begin
                r_count <= r_count + 1'b1;
              end
            end
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
          endcase

          if (w_event[gi] && !w_cons[gi] && (r_count == COUNT_MAX)) begin
            r_overflow <= 1'b1;
          end else if (overflow_clear[gi]) begin
            r_overflow <= 1'b0;
          end

          if (w_cons[gi]) begin
            r_ack <= ~r_ack;
          end
        end
      end

      assign ack_toggle_out[gi]                          = r_ack;
      assign overflow[gi]                                = r_overflow;
      assign pending[gi*COUNT_WIDTH +: COUNT_WIDTH]      = r_count;
    end
  endgenerate

  // Round-robin search starting at r_rr_ptr, wrapping modulo CHANNELS.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_ch    = '0;
    w_idx      = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_idx = (int'(r_rr_ptr) + i) % CHANNELS;
      if (!w_rr_found && w_nonzero[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_ch    = CH_WIDTH'(w_idx);
      end
    end
  end

  assign out_valid   = r_hold_valid | (|w_nonzero);
  assign out_channel = r_hold_valid ? r_hold_ch : w_rr_ch;
  assign w_accept    = out_valid && out_ready;

  // An offer that is not taken is frozen so the consumer sees a stable channel.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      r_hold_valid <= 1'b0;
      r_hold_ch    <= '0;
      r_rr_ptr     <= '0;
    end else if (w_accept) begin
      r_hold_valid <= 1'b0;
      if (out_channel == CH_WIDTH'(CHANNELS - 1)) begin
        r_rr_ptr <= '0;
      end else begin
        r_rr_ptr <= out_channel + 1'b1;
      end
    end else if (out_valid) begin
      r_hold_valid <= 1'b1;
      r_hold_ch    <= out_channel;
    end
  end

endmodule

// File: tb/tb_clock_cross_event_merge.sv
// Self-checking bench for clock_cross_event_merge: latency, round-robin table with a grant
// scoreboard, hold stability, saturation/overflow and asynchronous mid-operation reset.
module tb_clock_cross_event_merge;

  localparam int CHANNELS    = 4;
  localparam int META_STAGES = 2;
  localparam int COUNT_WIDTH = 4;

  logic        clock = 1'b0;
  logic        areset_n;
  logic [3:0]  toggle_in;
  logic [3:0]  ack_toggle_out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_channel;
  logic [15:0] pending;
  logic [3:0]  overflow;
  logic [3:0]  overflow_clear;

  clock_cross_event_merge #(
    .CHANNELS   (CHANNELS),
    .META_STAGES(META_STAGES),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .clock         (clock),
    .areset_n      (areset_n),
    .toggle_in     (toggle_in),
    .ack_toggle_out(ack_toggle_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_channel   (out_channel),
    .pending       (pending),
    .overflow      (overflow),
    .overflow_clear(overflow_clear)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] mask;
    int         n;
    logic [7:0] order;
  } vec_t;

  vec_t       vecs [7];
  logic [1:0] sb_q [$];
  logic [3:0] ack_exp;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic do_reset();
    areset_n       = 1'b0;
    toggle_in      = '0;
    out_ready      = 1'b0;
    overflow_clear = '0;
    ack_exp        = '0;
    repeat (2) @(negedge clock);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_channel", 32'(out_channel), 32'd0);
    chk("rst_ack", 32'(ack_toggle_out), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    areset_n = 1'b1;
    @(negedge clock);
  endtask

  // Returns at the falling edge just before the edge where the counter sees the flip.
  task automatic flip_to_update(input logic [3:0] m);
    @(negedge clock);
    toggle_in = toggle_in ^ m;
    repeat (META_STAGES) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_pend;
    logic [7:0]  ord;
    int          budget;

    vecs[0] = '{mask: 4'b1011, n: 3, order: 8'b00_11_01_00};
    vecs[1] = '{mask: 4'b0001, n: 1, order: 8'b00_00_00_00};
    vecs[2] = '{mask: 4'b1111, n: 4, order: 8'b00_11_10_01};
    vecs[3] = '{mask: 4'b0101, n: 2, order: 8'b00_00_00_10};
    vecs[4] = '{mask: 4'b1000, n: 1, order: 8'b00_00_00_11};
    vecs[5] = '{mask: 4'b0110, n: 2, order: 8'b00_00_10_01};
    vecs[6] = '{mask: 4'b0011, n: 2, order: 8'b00_00_01_00};

    do_reset();

    // Single event latency on channel 2.
    toggle_in[2] = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    chk("lat_valid_early", 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_channel", 32'(out_channel), 32'd2);
    chk("lat_pending", 32'(pending), 32'h0100);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("lat_ack", 32'(ack_toggle_out), 32'h4);
    chk("lat_pending_after", 32'(pending), 32'd0);
    chk("lat_valid_after", 32'(out_valid), 32'd0);

    do_reset();

    // Round-robin table: expected grants go into the scoreboard as the flips are driven.
    for (int v = 0; v < 7; v++) begin
      ord = vecs[v].order;
      for (int j = 0; j < vecs[v].n; j++) begin
        sb_q.push_back(ord[2*j +: 2]);
      end
      @(negedge clock);
      toggle_in = toggle_in ^ vecs[v].mask;
      ack_exp   = ack_exp ^ vecs[v].mask;
      repeat (META_STAGES + 2) @(negedge clock);
      exp_pend = '0;
      for (int c = 0; c < 4; c++) begin
        exp_pend[c*4 +: 4] = vecs[v].mask[c] ? 4'd1 : 4'd0;
      end
      chk($sformatf("v%0d_pending", v), 32'(pending), 32'(exp_pend));
      out_ready = 1'b1;
      budget    = 20;
      while (sb_q.size() > 0 && budget > 0) begin
        if (out_valid) begin
          chk($sformatf("v%0d_grant", v), 32'(out_channel), 32'(sb_q.pop_front()));
        end
        @(negedge clock);
        budget--;
      end
      out_ready = 1'b0;
      if (budget == 0) begin
        chk($sformatf("v%0d_grant_timeout", v), 32'(sb_q.size()), 32'd0);
        sb_q.delete();
      end
      chk($sformatf("v%0d_idle", v), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_ack", v), 32'(ack_toggle_out), 32'(ack_exp));
      chk($sformatf("v%0d_drained", v), 32'(pending), 32'd0);
    end

    do_reset();

    // Hold stability: channel 3 offered and held while channel 0 arrives with rr_ptr at 0.
    @(negedge clock);
    toggle_in[3] = ~toggle_in[3];
    repeat (META_STAGES + 2) @(negedge clock);
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_ch3", 32'(out_channel), 32'd3);
    toggle_in[0] = ~toggle_in[0];
    repeat (META_STAGES + 2) @(negedge clock);
    chk("hold_still_ch3", 32'(out_channel), 32'd3);
    chk("hold_pending", 32'(pending), 32'h1001);
    out_ready = 1'b1;
    @(negedge clock);
    chk("hold_next_ch0", 32'(out_channel), 32'd0);
    @(negedge clock);
    out_ready = 1'b0;
    ack_exp   = 4'b1001;
    chk("hold_idle", 32'(out_valid), 32'd0);
    chk("hold_ack", 32'(ack_toggle_out), 32'(ack_exp));

    // Saturation on channel 1.
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      toggle_in[1] = ~toggle_in[1];
    end
    repeat (META_STAGES + 2) @(negedge clock);
    chk("sat_pending", 32'(pending[7:4]), 32'd15);
    chk("sat_overflow", 32'(overflow), 32'h2);
    chk("sat_channel", 32'(out_channel), 32'd1);
    overflow_clear = 4'b0010;
    @(negedge clock);
    overflow_clear = '0;
    chk("sat_clear", 32'(overflow), 32'd0);

    flip_to_update(4'b0010);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready  = 1'b0;
    ack_exp[1] = ~ack_exp[1];
    chk("sat_both_pending", 32'(pending[7:4]), 32'd15);
    chk("sat_both_no_ovf", 32'(overflow), 32'd0);
    chk("sat_both_ack", 32'(ack_toggle_out), 32'(ack_exp));

    flip_to_update(4'b0010);
    overflow_clear = 4'b0010;
    @(posedge clock); #1;
    chk("sat_set_wins", 32'(overflow), 32'h2);
    @(posedge clock); #1;
    overflow_clear = '0;
    chk("sat_clear_after", 32'(overflow), 32'd0);

    @(negedge clock);
    out_ready = 1'b1;
    repeat (15) @(negedge clock);
    out_ready  = 1'b0;
    ack_exp[1] = ~ack_exp[1];
    chk("sat_drain_pending", 32'(pending), 32'd0);
    chk("sat_drain_valid", 32'(out_valid), 32'd0);
    chk("sat_drain_ack", 32'(ack_toggle_out), 32'(ack_exp));

    // Asynchronous reset with five queued events and an active hold on channel 0.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      toggle_in[0] = ~toggle_in[0];
    end
    repeat (META_STAGES + 2) @(negedge clock);
    chk("mid_pending", 32'(pending[3:0]), 32'd5);
    chk("mid_valid", 32'(out_valid), 32'd1);
    @(posedge clock);
    #3;
    areset_n  = 1'b0;
    toggle_in = '0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_pending", 32'(pending), 32'd0);
    chk("mid_rst_ack", 32'(ack_toggle_out), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_channel", 32'(out_channel), 32'd0);
    @(negedge clock);
    areset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("mid_no_spurious", 32'(out_valid), 32'd0);
    end
    chk("mid_end_pending", 32'(pending), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
